// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA raster timing generator with prescaler, sync polarity and run/pause (rev 1.0)
// Optional completed-frame counter: define VGA_TIMING_FRAME_CNT_EN to build it; otherwise frame_cnt_o is tied to 0.
`default_nettype none

module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int CLK_DIV    = 1,
   parameter int CW         = 10,
   parameter int FRAME_W    = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   output logic [CW-1:0]      x_o,
   output logic [CW-1:0]      y_o,
   output logic               h_sync_o,
   output logic               v_sync_o,
   output logic               display_on_o,
   output logic               pix_ce_o,
   output logic               line_start_o,
   output logic               frame_start_o,
   output logic [FRAME_W-1:0] frame_cnt_o
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CW-1:0]    C_X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]    C_Y_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]    C_X_VIS    = CW'(H_DISPLAY - 1);
   localparam logic [CW-1:0]    C_Y_VIS    = CW'(V_DISPLAY - 1);
   localparam logic [CW-1:0]    C_HS_FIRST = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0]    C_HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0]    C_VS_FIRST = CW'(V_DISPLAY + V_FRONT);
   localparam logic [CW-1:0]    C_VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic             C_HS_ACT   = (H_SYNC_POL != 0);
   localparam logic             C_VS_ACT   = (V_SYNC_POL != 0);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CW-1:0]    x_q, x_d, y_q, y_d;
   logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic             ce_q, ce_d, ls_q, ls_d, fs_q, fs_d;
   logic             w_adv, w_x_wrap, w_y_wrap;

   // Outputs are decoded from the next beam position so every output describes the same pixel.
   always_comb begin
      w_adv    = (div_q == C_DIV_LAST);
      w_x_wrap = (x_q == C_X_LAST);
      w_y_wrap = (y_q == C_Y_LAST);
      div_d    = w_adv ? '0 : div_q + 1'b1;
      x_d      = x_q;
      y_d      = y_q;
      if (w_adv) begin
         x_d = w_x_wrap ? '0 : x_q + 1'b1;
         if (w_x_wrap) begin
            y_d = w_y_wrap ? '0 : y_q + 1'b1;
         end
      end
      ce_d = (div_d == '0);
      ls_d = ce_d && (x_d == '0);
      fs_d = ls_d && (y_d == '0);
      hs_d = ((x_d >= C_HS_FIRST) && (x_d <= C_HS_LAST)) ? C_HS_ACT : ~C_HS_ACT;
      vs_d = ((y_d >= C_VS_FIRST) && (y_d <= C_VS_LAST)) ? C_VS_ACT : ~C_VS_ACT;
      de_d = (x_d <= C_X_VIS) && (y_d <= C_Y_VIS);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= ~C_HS_ACT;
         vs_q  <= ~C_VS_ACT;
         de_q  <= 1'b1;
         ce_q  <= 1'b1;
         ls_q  <= 1'b1;
         fs_q  <= 1'b1;
      end else if (en_i) begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
         ce_q  <= ce_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_W-1:0] frame_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_q <= '0;
      end else if (en_i && w_adv && w_x_wrap && w_y_wrap) begin
         frame_q <= frame_q + 1'b1;
      end
   end

   assign frame_cnt_o = frame_q;
`else
   assign frame_cnt_o = '0;
`endif

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign h_sync_o      = hs_q;
   assign v_sync_o      = vs_q;
   assign display_on_o  = de_q;
   assign pix_ce_o      = ce_q;
   assign line_start_o  = ls_q;
   assign frame_start_o = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- two small-mode instances (prescaled/inverted-h-sync and undivided) against a time-based raster model (rev 1.0)
`default_nettype none

module tb_vga_timing_gen;

   // Instance A: CLK_DIV=3, h_sync active-high, 15x10 raster
   localparam int AHD = 8, AHF = 2, AHS = 3, AHB = 2, AVD = 6, AVF = 1, AVS = 2, AVB = 1;
   localparam int AD = 3, ACW = 5, AFW = 2;
   localparam int AHT = AHD + AHF + AHS + AHB, AVT = AVD + AVF + AVS + AVB;
   // Instance B: CLK_DIV=1, both syncs active-low, 14x8 raster
   localparam int BHD = 10, BHF = 1, BHS = 2, BHB = 1, BVD = 4, BVF = 1, BVS = 1, BVB = 2;
   localparam int BD = 1, BCW = 4, BFW = 3;
   localparam int BHT = BHD + BHF + BHS + BHB, BVT = BVD + BVF + BVS + BVB;

   typedef struct packed {
      int x; int y; logic hs; logic vs; logic de; logic ce; logic ls; logic fs; int fc;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic [ACW-1:0] xa, ya;
   logic [BCW-1:0] xb, yb;
   logic hsa, vsa, dea, cea, lsa, fsa, hsb, vsb, deb, ceb, lsb, fsb;
   logic [AFW-1:0] fca;
   logic [BFW-1:0] fcb;
   longint t;
   int checks = 0, failures = 0;
   logic [17:0] obs_a, exp_a;
   logic [16:0] obs_b, exp_b;

   vga_timing_gen #(.H_DISPLAY(AHD), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
      .V_DISPLAY(AVD), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB), .H_SYNC_POL(1), .V_SYNC_POL(0),
      .CLK_DIV(AD), .CW(ACW), .FRAME_W(AFW)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_o(xa), .y_o(ya), .h_sync_o(hsa), .v_sync_o(vsa),
      .display_on_o(dea), .pix_ce_o(cea), .line_start_o(lsa), .frame_start_o(fsa), .frame_cnt_o(fca));

   vga_timing_gen #(.H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB), .H_SYNC_POL(0), .V_SYNC_POL(0),
      .CLK_DIV(BD), .CW(BCW), .FRAME_W(BFW)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_o(xb), .y_o(yb), .h_sync_o(hsb), .v_sync_o(vsb),
      .display_on_o(deb), .pix_ce_o(ceb), .line_start_o(lsb), .frame_start_o(fsb), .frame_cnt_o(fcb));

   always #5 clk = ~clk;

   // Model state is just the number of enabled clocks since reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) t <= 0;
      else if (en) t <= t + 1;
   end

   function automatic exp_t model(input longint tt, input int d, input int hd, input int hf, input int hs,
                                  input int hb, input int vd, input int vf, input int vs, input int vb,
                                  input logic hp, input logic vp, input int fw);
      exp_t e;
      longint ht, vt, pix;
      ht   = hd + hf + hs + hb;
      vt   = vd + vf + vs + vb;
      pix  = tt / d;
      e.x  = int'(pix % ht);
      e.y  = int'((pix / ht) % vt);
      e.ce = ((tt % d) == 0);
      e.ls = e.ce && (e.x == 0);
      e.fs = e.ls && (e.y == 0);
      e.de = (e.x < hd) && (e.y < vd);
      e.hs = (e.x >= hd + hf && e.x < hd + hf + hs) ? hp : !hp;
      e.vs = (e.y >= vd + vf && e.y < vd + vf + vs) ? vp : !vp;
`ifdef VGA_TIMING_FRAME_CNT_EN
      e.fc = int'((pix / (ht * vt)) % (longint'(1) << fw));
`else
      e.fc = fw * 0;
`endif
      return e;
   endfunction

   function automatic logic [17:0] pack_a(input exp_t e);
      return {5'(e.x), 5'(e.y), e.hs, e.vs, e.de, e.ce, e.ls, e.fs, 2'(e.fc)};
   endfunction

   function automatic logic [16:0] pack_b(input exp_t e);
      return {4'(e.x), 4'(e.y), e.hs, e.vs, e.de, e.ce, e.ls, e.fs, 3'(e.fc)};
   endfunction

   assign obs_a = {xa, ya, hsa, vsa, dea, cea, lsa, fsa, fca};
   assign obs_b = {xb, yb, hsb, vsb, deb, ceb, lsb, fsb, fcb};

   always_comb begin
      exp_a = pack_a(model(t, AD, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB, 1'b1, 1'b0, AFW));
      exp_b = pack_b(model(t, BD, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB, 1'b0, 1'b0, BFW));
   end

   task automatic test_reset();
      @(negedge clk);
      checks += 2;
      if (obs_a !== {5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 2'd0}) begin
         failures++; $display("FAIL reset_A got=%h exp=%h", obs_a, {5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 2'd0});
      end
      if (obs_b !== {4'd0, 4'd0, 1'b1, 1'b1, 4'b1111, 3'd0}) begin
         failures++; $display("FAIL reset_B got=%h exp=%h", obs_b, {4'd0, 4'd0, 1'b1, 1'b1, 4'b1111, 3'd0});
      end
   endtask

   task automatic test_frames_and_counts();
      int de_a = 0, hs_a = 0, ce_a = 0, ls_a = 0, fs_a = 0, de_b = 0, hs_b = 0, vs_b = 0, fs_b = 0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; en = 1'b1;
      for (int i = 0; i < 1600; i++) begin
         checks += 2;
         if (obs_a !== exp_a) begin failures++; $display("FAIL run_A t=%0d got=%h exp=%h", t, obs_a, exp_a); end
         if (obs_b !== exp_b) begin failures++; $display("FAIL run_B t=%0d got=%h exp=%h", t, obs_b, exp_b); end
         if (i < AHT * AVT * AD) begin
            de_a += int'(dea); hs_a += int'(hsa); ce_a += int'(cea); ls_a += int'(lsa); fs_a += int'(fsa);
         end
         if (i < BHT * BVT * BD) begin
            de_b += int'(deb); hs_b += int'(!hsb); vs_b += int'(!vsb); fs_b += int'(fsb);
         end
         @(negedge clk);
      end
      checks += 9;
      if (de_a != AHD * AVD * AD) begin failures++; $display("FAIL de_clks_A got=%0d exp=%0d", de_a, AHD * AVD * AD); end
      if (hs_a != AHS * AVT * AD) begin failures++; $display("FAIL hs_clks_A got=%0d exp=%0d", hs_a, AHS * AVT * AD); end
      if (ce_a != AHT * AVT) begin failures++; $display("FAIL ce_clks_A got=%0d exp=%0d", ce_a, AHT * AVT); end
      if (ls_a != AVT) begin failures++; $display("FAIL ls_clks_A got=%0d exp=%0d", ls_a, AVT); end
      if (fs_a != 1) begin failures++; $display("FAIL fs_clks_A got=%0d exp=1", fs_a); end
      if (de_b != BHD * BVD) begin failures++; $display("FAIL de_clks_B got=%0d exp=%0d", de_b, BHD * BVD); end
      if (hs_b != BHS * BVT) begin failures++; $display("FAIL hs_clks_B got=%0d exp=%0d", hs_b, BHS * BVT); end
      if (vs_b != BVS * BHT) begin failures++; $display("FAIL vs_clks_B got=%0d exp=%0d", vs_b, BVS * BHT); end
      if (fs_b != 1) begin failures++; $display("FAIL fs_clks_B got=%0d exp=1", fs_b); end
   endtask

   task automatic test_pause();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; en = 1'b1;
      for (int i = 0; i < 235; i++) begin
         if (i == 165) en = 1'b0;
         if (i == 215) en = 1'b1;
         @(negedge clk);
         checks += 2;
         if (obs_a !== exp_a) begin failures++; $display("FAIL pause_A t=%0d got=%h exp=%h", t, obs_a, exp_a); end
         if (obs_b !== exp_b) begin failures++; $display("FAIL pause_B t=%0d got=%h exp=%h", t, obs_b, exp_b); end
         if (i == 200) begin
            checks++;
            if ({xa, ya, cea} !== {5'd10, 5'd3, 1'b1}) begin
               failures++; $display("FAIL pause_hold_A got=%h exp=%h", {xa, ya, cea}, {5'd10, 5'd3, 1'b1});
            end
         end
      end
   endtask

   task automatic test_random_en();
      for (int i = 0; i < 2500; i++) begin
         en = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks += 2;
         if (obs_a !== exp_a) begin failures++; $display("FAIL rand_A t=%0d got=%h exp=%h", t, obs_a, exp_a); end
         if (obs_b !== exp_b) begin failures++; $display("FAIL rand_B t=%0d got=%h exp=%h", t, obs_b, exp_b); end
      end
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      repeat ($urandom_range(200, 400)) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks += 2;
      if (obs_a !== {5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 2'd0}) begin
         failures++; $display("FAIL async_rst_A got=%h exp=%h", obs_a, {5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 2'd0});
      end
      if (obs_b !== {4'd0, 4'd0, 1'b1, 1'b1, 4'b1111, 3'd0}) begin
         failures++; $display("FAIL async_rst_B got=%h exp=%h", obs_b, {4'd0, 4'd0, 1'b1, 1'b1, 4'b1111, 3'd0});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         checks += 2;
         if (obs_a !== exp_a) begin failures++; $display("FAIL post_rst_A t=%0d got=%h exp=%h", t, obs_a, exp_a); end
         if (obs_b !== exp_b) begin failures++; $display("FAIL post_rst_B t=%0d got=%h exp=%h", t, obs_b, exp_b); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_frames_and_counts();
      test_pause();
      test_random_en();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
